fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, the byte address fetched first after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the instruction buffer entry count (fixed at 2; other values unsupported).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned byte address of the request.
REQ-007 imem_ack  input  1  imem_rdata valid; meaningful only while imem_req=1.
REQ-008 imem_rdata  input  32  returned instruction word.
REQ-009 redirect_valid  input  1  branch/jump/jr taken; next PC comes from redirect_pc.
REQ-010 redirect_pc  input  32  redirect target byte address.
REQ-011 stall  input  1  decode cannot accept a new IF/ID word this cycle.
REQ-012 if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 if_id_inst  output  32  IF/ID instruction word.
REQ-014 if_id_pc_4  output  32  fetch address of if_id_inst plus 4.

Function
REQ-015 SHALL track one outstanding request with FSM states IDLE (none outstanding), WAIT (outstanding, keep data), DISCARD (outstanding, drop data).
REQ-016 imem_req SHALL be 1 in WAIT and DISCARD; imem_addr SHALL stay constant from issue until the acked cycle.
REQ-017 A request SHALL issue (IDLE->WAIT, or WAIT->WAIT on an ack) only when buffer occupancy after this cycle's push/pop plus outstanding requests is less than 2.
REQ-018 On ack in WAIT: push {imem_rdata, imem_addr+4} into the buffer; PC advances by 4, wrapping modulo 2^32.
REQ-019 IF/ID register SHALL load the buffer head when buffer non-empty and (stall=0 or if_id_valid=0); it SHALL hold when stall=1 and if_id_valid=1.
REQ-020 If the buffer is empty and the register loads, if_id_valid SHALL go 0 and if_id_inst and if_id_pc_4 SHALL hold.
REQ-021 redirect_valid SHALL take priority over stall: next edge flushes the buffer, clears if_id_valid, and sets PC to {redirect_pc[31:2],2'b00}.
REQ-022 Redirect while a request is outstanding and unacked: WAIT->DISCARD; the later ack SHALL be dropped, then DISCARD->IDLE.
REQ-023 Redirect coincident with ack: returned data dropped; state IDLE; first request to the target SHALL issue the following cycle.
REQ-024 Best-case redirect-to-if_id_valid latency SHALL be 3 cycles with single-cycle memory ack.
REQ-025 Steady-state throughput with single-cycle ack and stall=0 SHALL be one instruction per cycle.

Reset
REQ-026 During reset: state IDLE, PC=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_inst=0, if_id_pc_4=0.
REQ-027 The first request SHALL issue in the first cycle after reset deasserts; reset mid-request SHALL abandon it, and any late ack SHALL be ignored because imem_req=0.

Configuration
REQ-028 With FETCH_PERF_EN defined: add outputs fetch_count[31:0] (increments per word pushed) and stall_count[31:0] (increments per cycle with stall=1 and if_id_valid=1), both reset to 0 and wrapping.
REQ-029 Without FETCH_PERF_EN: those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 Shared package mips_pkg SHALL hold the fetch FSM state enum, the default RESET_PC constant, and the NOP word 32'h0000_0000.
REQ-031 The buffer SHALL be sub-module fetch_buffer: 2-entry synchronous FIFO with push/pop/flush, full/empty, and 64-bit entries.

Verification
REQ-032 Reset release, ack every cycle, memory returns addr^32'hFFFF_FFFF -> if_id_pc_4 = 0x0040_0004, 0x0040_0008, ... on consecutive cycles.
REQ-033 stall held 5 cycles with if_id_valid=1 -> if_id_inst unchanged; at most 2 further acks accepted; no word lost or duplicated after release.
REQ-034 redirect_valid with redirect_pc=0x0040_0103 while WAIT and ack delayed 4 cycles -> late word dropped; next imem_addr=0x0040_0100; if_id_pc_4=0x0040_0104.
REQ-035 redirect and ack in the same cycle, plus stall=1 -> if_id_valid=0 next cycle; request to the target issues the cycle after.
REQ-036 PC=0xFFFF_FFFC fetched -> if_id_pc_4=0x0000_0000; next imem_addr=0x0000_0000.
REQ-037 reset asserted with imem_req=1, ack arriving during reset -> outputs at reset values; first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   fetchState_t     : fetch FSM states (IDLE / WAIT / DISCARD)
//   DEFAULT_RESET_PC : byte address fetched first after reset
//   NOP_WORD         : instruction word used as the IF/ID reset value
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,     // no request outstanding
    WAIT,     // request outstanding, returned word is kept
    DISCARD   // request outstanding, returned word is dropped
  } fetchState_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO between instruction memory and the IF/ID register.
// Entries are {instruction, fetch address + 4}.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   push, pushData    : write an entry (ignored when full and not popping)
//   pop               : remove the head entry (ignored when empty)
//   flush             : discard all entries; takes priority over push/pop
//   headData          : current head entry (valid when empty=0)
//   full, empty       : occupancy flags
module fetch_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] pushData,
  output logic [63:0] headData,
  output logic        full,
  output logic        empty
);

  logic [63:0] mem [2];
  logic        rdPtr;
  logic        wrPtr;
  logic [1:0]  count;
  logic        doPush;
  logic        doPop;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= ~wrPtr;
      if (doPop)  rdPtr <= ~rdPtr;
      count <= count + {1'b0, doPush} - {1'b0, doPop};
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a 2-entry
// instruction buffer and the IF/ID pipeline register.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   imem_req/imem_addr          : request and word-aligned byte address
//   imem_ack/imem_rdata         : response strobe and instruction word
//   redirect_valid/redirect_pc  : taken branch/jump; overrides stall
//   stall                       : decode cannot accept a new word
//   if_id_valid/inst/pc_4       : IF/ID register contents
// Optional macro FETCH_PERF_EN adds fetch_count and stall_count outputs.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [2:0] BUF_CAP = 3'(BUF_DEPTH);

  fetchState_t state;
  fetchState_t stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] addrReg;
  logic        push;
  logic        load;
  logic        pop;
  logic        issue;
  logic        bufFull;
  logic        bufEmpty;
  logic [63:0] headData;
  logic [1:0]  occCur;
  logic [2:0]  occNext;

  // pc is the next address to fetch; addrReg is the address presented to
  // memory, frozen from issue until ack even after a redirect moves pc.
  assign imem_req  = (state != IDLE);
  assign imem_addr = addrReg;

  assign push    = (state == WAIT) && imem_ack && !redirect_valid;
  assign load    = !redirect_valid && (!stall || !if_id_valid);
  assign pop     = load && !bufEmpty;
  assign occCur  = {bufFull, !bufFull && !bufEmpty};
  assign occNext = {1'b0, occCur} + {2'b00, push} - {2'b00, pop};

  always_comb begin
    pcNext = pc;
    if (redirect_valid) pcNext = {redirect_pc[31:2], 2'b00};
    else if (push)      pcNext = pc + 32'd4;
  end

  // A new request may only go out if its response is guaranteed a buffer slot.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect_valid && (occNext < BUF_CAP)) begin
          issue     = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (!redirect_valid && (occNext < BUF_CAP)) issue = 1'b1;
          else                                        stateNext = IDLE;
        end else if (redirect_valid) begin
          stateNext = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      addrReg <= RESET_PC;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (issue) addrReg <= pcNext;
    end
  end

  fetch_buffer u_buffer (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .pushData ({imem_rdata, imem_addr + 32'd4}),
    .headData (headData),
    .full     (bufFull),
    .empty    (bufEmpty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_WORD;
      if_id_pc_4  <= '0;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
    end else if (load) begin
      // An empty buffer yields a bubble but keeps the last word/pc visible.
      if_id_valid <= !bufEmpty;
      if (!bufEmpty) begin
        if_id_inst <= headData[63:32];
        if_id_pc_4 <= headData[31:0];
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push)                 fetch_count <= fetch_count + 32'd1;
      if (stall && if_id_valid) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Memory returns ~address as data.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_4;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;
`endif

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_id_valid    (if_id_valid),
    .if_id_inst     (if_id_inst),
    .if_id_pc_4     (if_id_pc_4)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetchCount),
    .stall_count    (stallCount)
`endif
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hFFFF_FFFF;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        ack;
    logic        expReq;
    logic        addrCare;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInst;
    logic [31:0] expPc4;
  } vec_t;

  vec_t        vecs[16];
  logic [31:0] expQ[$];
  logic [31:0] lastInst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic [31:0] rp, input logic st,
                              input logic ak, input logic rq, input logic ac,
                              input logic [31:0] ad, input logic vl,
                              input logic [31:0] in, input logic [31:0] p4);
    vec_t v;
    v.redir = rd; v.rpc = rp; v.stl = st; v.ack = ak; v.expReq = rq;
    v.addrCare = ac; v.expAddr = ad; v.expValid = vl; v.expInst = in; v.expPc4 = p4;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle with no redirect; scoreboard pops when a new word reaches IF/ID.
  task automatic cycle(input logic st, input logic ak, output logic newInst, output logic ackTaken);
    logic held;
    logic [31:0] a;
    redirect_valid = 1'b0;
    stall          = st;
    imem_ack       = ak;
    held     = st && if_id_valid;
    ackTaken = imem_req && ak;
    step();
    newInst = if_id_valid && !held;
    if (held) chk("stall_hold_inst", if_id_inst, lastInst);
    if (newInst) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual_pc4=%h expected=none", if_id_pc_4);
      end else begin
        a = expQ.pop_front();
        chk("sb_pc4", if_id_pc_4, a + 32'd4);
        chk("sb_inst", if_id_inst, a ^ 32'hFFFF_FFFF);
        lastInst = a ^ 32'hFFFF_FFFF;
      end
    end
  endtask

  task automatic fillQ(input logic [31:0] base, input int unsigned n);
    expQ.delete();
    for (int unsigned i = 0; i < n; i++) expQ.push_back(base + 32'(4 * i));
  endtask

  initial begin
    logic ni;
    logic at;
    int   newCnt;
    int   ackCnt;

    // straight-line run, redirect with delayed ack, wrap at top of memory
    vecs[0]  = mk(0, 0, 0, 1, 1, 1, 32'h0040_0000, 0, 32'h0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 1, 1, 1, 32'h0040_0004, 0, 32'h0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 1, 1, 1, 32'h0040_0008, 1, 32'hFFBF_FFFF, 32'h0040_0004);
    vecs[3]  = mk(0, 0, 0, 1, 1, 1, 32'h0040_000C, 1, 32'hFFBF_FFFB, 32'h0040_0008);
    vecs[4]  = mk(1, 32'h0040_0103, 0, 0, 1, 1, 32'h0040_000C, 0, 32'hFFBF_FFFB, 32'h0040_0008);
    vecs[5]  = mk(0, 0, 0, 0, 1, 1, 32'h0040_000C, 0, 32'hFFBF_FFFB, 32'h0040_0008);
    vecs[6]  = mk(0, 0, 0, 0, 1, 1, 32'h0040_000C, 0, 32'hFFBF_FFFB, 32'h0040_0008);
    vecs[7]  = mk(0, 0, 0, 0, 1, 1, 32'h0040_000C, 0, 32'hFFBF_FFFB, 32'h0040_0008);
    vecs[8]  = mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 32'hFFBF_FFFB, 32'h0040_0008);
    vecs[9]  = mk(0, 0, 0, 1, 1, 1, 32'h0040_0100, 0, 32'hFFBF_FFFB, 32'h0040_0008);
    vecs[10] = mk(0, 0, 0, 1, 1, 1, 32'h0040_0104, 0, 32'hFFBF_FFFB, 32'h0040_0008);
    vecs[11] = mk(0, 0, 0, 1, 1, 1, 32'h0040_0108, 1, 32'hFFBF_FEFF, 32'h0040_0104);
    vecs[12] = mk(1, 32'hFFFF_FFFC, 1, 1, 0, 0, 32'h0, 0, 32'hFFBF_FEFF, 32'h0040_0104);
    vecs[13] = mk(0, 0, 1, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'hFFBF_FEFF, 32'h0040_0104);
    vecs[14] = mk(0, 0, 0, 1, 1, 1, 32'h0000_0000, 0, 32'hFFBF_FEFF, 32'h0040_0104);
    vecs[15] = mk(0, 0, 0, 1, 1, 1, 32'h0000_0004, 1, 32'h0000_0003, 32'h0000_0000);

    reset = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    lastInst = '0;
    step();
    step();
    chk("rst_req",   {31'b0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            RST_PC);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_inst",  if_id_inst,           32'd0);
    chk("rst_pc4",   if_id_pc_4,           32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      stall          = vecs[i].stl;
      imem_ack       = vecs[i].ack;
      step();
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
      if (vecs[i].addrCare) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
      chk($sformatf("vec%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].expValid});
      chk($sformatf("vec%0d_inst", i), if_id_inst, vecs[i].expInst);
      chk($sformatf("vec%0d_pc4", i), if_id_pc_4, vecs[i].expPc4);
    end

    // redirect, best-case latency, then stall for 5 cycles and release
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000; stall = 1'b0; imem_ack = 1'b1;
    step();
    chk("redir_valid_clear", {31'b0, if_id_valid}, 32'd0);
    fillQ(32'h0000_1000, 40);
    cycle(1'b0, 1'b1, ni, at);
    chk("lat_c1_valid", {31'b0, if_id_valid}, 32'd0);
    cycle(1'b0, 1'b1, ni, at);
    chk("lat_c2_valid", {31'b0, if_id_valid}, 32'd0);
    cycle(1'b0, 1'b1, ni, at);
    chk("lat_c3_valid", {31'b0, if_id_valid}, 32'd1);
    cycle(1'b0, 1'b1, ni, at);
    cycle(1'b0, 1'b1, ni, at);
    ackCnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, ni, at);
      if (at) ackCnt++;
    end
    chk("stall_acks_le2", {31'b0, ackCnt <= 2}, 32'd1);
    chk("stall_valid", {31'b0, if_id_valid}, 32'd1);
    newCnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, ni, at);
      if (ni) newCnt++;
    end
    chk("throughput", 32'(newCnt), 32'd8);

    // reset while a request is outstanding, with acks arriving during reset
    chk("pre_reset_req", {31'b0, imem_req}, 32'd1);
    reset = 1'b1; imem_ack = 1'b1;
    #1;
    chk("mid_rst_req",   {31'b0, imem_req},    32'd0);
    chk("mid_rst_addr",  imem_addr,            RST_PC);
    chk("mid_rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("mid_rst_inst",  if_id_inst,           32'd0);
    chk("mid_rst_pc4",   if_id_pc_4,           32'd0);
    step();
    step();
    chk("hold_rst_req",  {31'b0, imem_req}, 32'd0);
    chk("hold_rst_addr", imem_addr,         RST_PC);
    reset = 1'b0;
    step();
    chk("post_rst_req",  {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr,         RST_PC);
    fillQ(RST_PC, 8);
    lastInst = '0;
    newCnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, ni, at);
      if (ni) newCnt++;
    end
    chk("post_rst_words", 32'(newCnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
